// File: rtl/sb_bus_pkg.sv
// sb_bus_pkg: shared system-bus widths and the RAM responder state encoding.
package sb_bus_pkg;
    localparam int SB_DATA_W  = 32;
    localparam int SB_BURST_W = 8;
    localparam int SB_BE_W    = 4;

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, ERR, ERR_END
    } sb_slave_state_t;
endpackage

// File: rtl/sb_ram_array.sv
// sb_ram_array: single-port word RAM with synchronous read and byte-enabled synchronous write.
module sb_ram_array
    import sb_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [SB_BE_W-1:0]    be,
    input  logic [SB_DATA_W-1:0]  wdata,
    output logic [SB_DATA_W-1:0]  rdata
);
    logic [SB_DATA_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < SB_BE_W; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/sb_ram_slave.sv
// sb_ram_slave: on-chip RAM responding to single/burst bus reads and writes.
// Outputs are zero whenever the block is not actively responding, so they can be OR'd onto the bus.
module sb_ram_slave
    import sb_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          ADDR_WIDTH   = 10,
    parameter int          READ_LATENCY = 2
) (
    input  logic                  sb_clock_i,
    input  logic                  sb_reset_n_i,
    input  logic                  sb_begin_transaction_i,
    input  logic                  sb_end_transaction_i,
    input  logic [SB_DATA_W-1:0]  sb_address_data_i,
    input  logic [SB_BE_W-1:0]    sb_byte_enables_i,
    input  logic [SB_BURST_W-1:0] sb_burst_size_i,
    input  logic                  sb_read_n_write_i,
    input  logic                  sb_data_valid_i,
    input  logic                  sb_busy_i,
    input  logic                  sb_error_i,
    output logic [SB_DATA_W-1:0]  sb_address_data_o,
    output logic                  sb_data_valid_o,
    output logic                  sb_end_transaction_o,
    output logic                  sb_error_o,
    output logic                  sb_busy_o
);
    sb_slave_state_t       state, state_n;
    logic [ADDR_WIDTH-1:0] idx, idx_n;
    logic [8:0]            beats, beats_n;
    logic [7:0]            wcnt, wcnt_n;
    logic [SB_DATA_W-1:0]  rdata;
    logic [32:0]           span;
    logic                  hit, illegal, abort, beat, we;

    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) begin
            state <= IDLE;
            idx   <= '0;
            beats <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            beats <= beats_n;
            wcnt  <= wcnt_n;
        end
    end

    always_comb begin
        hit     = sb_begin_transaction_i &&
                  (sb_address_data_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
        span    = 33'(sb_address_data_i[ADDR_WIDTH+1:2]) + 33'(sb_burst_size_i);
        illegal = (sb_address_data_i[1:0] != 2'b00) || ((span >> ADDR_WIDTH) != '0);
        abort   = sb_error_i || sb_end_transaction_i;
        beat    = (state == RD_DATA) && !sb_busy_i && !abort;
        we      = (state == WR_DATA) && sb_data_valid_i && (beats != '0) && !sb_error_i;
        state_n = state;
        idx_n   = idx;
        beats_n = beats;
        wcnt_n  = wcnt;
        case (state)
            IDLE: if (hit) begin
                idx_n   = sb_address_data_i[ADDR_WIDTH+1:2];
                beats_n = 9'(sb_burst_size_i) + 9'd1;
                wcnt_n  = '0;
                state_n = illegal ? ERR : !sb_read_n_write_i ? WR_DATA :
                          (READ_LATENCY == 1) ? RD_DATA : RD_WAIT;
            end
            RD_WAIT: begin
                wcnt_n  = wcnt + 8'd1;
                state_n = abort ? IDLE : (32'(wcnt) == READ_LATENCY - 2) ? RD_DATA : RD_WAIT;
            end
            RD_DATA: if (abort) state_n = IDLE;
                else if (beat) begin
                    idx_n   = idx + 1'b1;
                    beats_n = beats - 9'd1;
                    state_n = (beats == 9'd1) ? RD_END : RD_DATA;
                end
            RD_END:  state_n = IDLE;
            WR_DATA: begin
                if (we) begin
                    idx_n   = idx + 1'b1;
                    beats_n = beats - 9'd1;
                end
                state_n = abort ? IDLE : WR_DATA;
            end
            ERR:     state_n = ERR_END;
            default: state_n = IDLE;
        endcase
    end

    // The RAM address is the next cycle's index so read data lines up with the beat it serves.
    sb_ram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (sb_clock_i),
        .addr  (we ? idx : idx_n),
        .we    (we),
        .be    (sb_byte_enables_i),
        .wdata (sb_address_data_i),
        .rdata (rdata)
    );

    assign sb_data_valid_o      = beat;
    assign sb_address_data_o    = beat ? rdata : '0;
    assign sb_end_transaction_o = (state == RD_END) || (state == ERR_END);
    assign sb_error_o           = (state == ERR);
    assign sb_busy_o            = 1'b0;
endmodule

// File: tb/tb_sb_ram_slave.sv
// tb_sb_ram_slave: directed checks of reads, writes, byte enables, errors, aborts and reset.
module tb_sb_ram_slave;
    import sb_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        b_begin = 1'b0, b_end = 1'b0, b_rnw = 1'b1, b_dv = 1'b0, b_busy = 1'b0, b_err = 1'b0;
    logic [31:0] b_ad = '0;
    logic [3:0]  b_be = '0;
    logic [7:0]  b_burst = '0;
    logic [31:0] o_ad;
    logic        o_dv, o_end, o_err, o_busy;

    int n_cmp = 0, n_fail = 0;
    logic [31:0] od [32];
    logic        ov [32], oe [32], oer [32];

    sb_ram_slave dut (
        .sb_clock_i             (clk),
        .sb_reset_n_i           (rst_n),
        .sb_begin_transaction_i (b_begin),
        .sb_end_transaction_i   (b_end),
        .sb_address_data_i      (b_ad),
        .sb_byte_enables_i      (b_be),
        .sb_burst_size_i        (b_burst),
        .sb_read_n_write_i      (b_rnw),
        .sb_data_valid_i        (b_dv),
        .sb_busy_i              (b_busy),
        .sb_error_i             (b_err),
        .sb_address_data_o      (o_ad),
        .sb_data_valid_o        (o_dv),
        .sb_end_transaction_o   (o_end),
        .sb_error_o             (o_err),
        .sb_busy_o              (o_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [7:0] burst, input int n,
                             input logic [127:0] d, input logic [15:0] be);
        b_begin = 1'b1; b_ad = addr; b_burst = burst; b_rnw = 1'b0;
        step();
        b_begin = 1'b0; b_burst = '0;
        for (int i = 0; i < n; i++) begin
            b_ad = d[32*i +: 32]; b_be = be[4*i +: 4]; b_dv = 1'b1; b_end = (i == n - 1);
            step();
        end
        b_ad = '0; b_be = '0; b_dv = 1'b0; b_end = 1'b0; b_rnw = 1'b1;
    endtask

    // Cycle 0 is the begin cycle; outputs of every cycle are recorded at the falling edge.
    task automatic run_read(input logic [31:0] addr, input logic [7:0] burst,
                            input logic [31:0] busy_mask, input logic [31:0] err_mask, input int ncyc);
        b_rnw = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            b_begin = (c == 0); b_ad = (c == 0) ? addr : '0; b_burst = (c == 0) ? burst : '0;
            b_busy = busy_mask[c]; b_err = err_mask[c];
            @(negedge clk);
            od[c] = o_ad; ov[c] = o_dv; oe[c] = o_end; oer[c] = o_err;
            step();
        end
        b_begin = 1'b0; b_ad = '0; b_burst = '0; b_busy = 1'b0; b_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({o_ad, o_dv, o_end, o_err, o_busy} !== 36'd0) begin
            n_fail++; $display("FAIL reset_outputs got %h want 0", {o_ad, o_dv, o_end, o_err, o_busy});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        bus_write(32'h400, 8'd0, 1, 128'hDEAD_BEEF, 16'hF);
        run_read(32'h400, 8'd0, '0, '0, 6);
        n_cmp++;
        if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", ov[1]); end
        n_cmp++;
        if (ov[2] !== 1'b1 || od[2] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_beat got v=%b d=%h want v=1 d=deadbeef", ov[2], od[2]);
        end
        n_cmp++;
        if (oe[3] !== 1'b1 || ov[3] !== 1'b0 || od[3] !== 32'd0) begin
            n_fail++; $display("FAIL single_end got e=%b v=%b d=%h want e=1 v=0 d=0", oe[3], ov[3], od[3]);
        end
        n_cmp++;
        if ({oe[2], oe[4], ov[4], od[4], oe[5], ov[5]} !== 37'd0) begin
            n_fail++; $display("FAIL single_quiet got e2=%b e4=%b v4=%b d4=%h e5=%b v5=%b want 0",
                               oe[2], oe[4], ov[4], od[4], oe[5], ov[5]);
        end
    endtask

    task automatic test_burst_stall();
        logic [31:0] exp_d [8];
        logic        exp_v [8];
        exp_d = '{0, 0, 1, 2, 0, 3, 4, 0};
        exp_v = '{0, 0, 1, 1, 0, 1, 1, 0};
        bus_write(32'h0, 8'd3, 4, {32'd4, 32'd3, 32'd2, 32'd1}, 16'hFFFF);
        run_read(32'h0, 8'd3, 32'h10, '0, 9);
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (ov[c] !== exp_v[c] || od[c] !== exp_d[c]) begin
                n_fail++; $display("FAIL burst_cycle%0d got v=%b d=%h want v=%b d=%h", c, ov[c], od[c], exp_v[c], exp_d[c]);
            end
        end
        n_cmp++;
        if (oe[7] !== 1'b1 || oe[6] !== 1'b0 || oe[8] !== 1'b0) begin
            n_fail++; $display("FAIL burst_end got e6=%b e7=%b e8=%b want 0 1 0", oe[6], oe[7], oe[8]);
        end
    endtask

    task automatic test_byte_enable();
        bus_write(32'h14, 8'd0, 1, 128'h5566_7788, 16'hF);
        bus_write(32'h10, 8'd1, 2, {32'h1122_3344, 32'hAABB_CCDD}, {4'b0101, 4'b1111});
        run_read(32'h10, 8'd1, '0, '0, 5);
        n_cmp++;
        if (ov[2] !== 1'b1 || od[2] !== 32'hAABB_CCDD) begin
            n_fail++; $display("FAIL be_word0 got v=%b d=%h want v=1 d=aabbccdd", ov[2], od[2]);
        end
        n_cmp++;
        if (ov[3] !== 1'b1 || od[3] !== 32'h5522_7744) begin
            n_fail++; $display("FAIL be_word1 got v=%b d=%h want v=1 d=55227744", ov[3], od[3]);
        end
        n_cmp++;
        if (oe[4] !== 1'b1) begin n_fail++; $display("FAIL be_end got %b want 1", oe[4]); end
    endtask

    task automatic test_extra_beats();
        bus_write(32'h24, 8'd0, 1, 128'h9999, 16'hF);
        bus_write(32'h20, 8'd0, 2, {32'h2222, 32'h1111}, 16'hFF);
        run_read(32'h20, 8'd1, '0, '0, 5);
        n_cmp++;
        if (od[2] !== 32'h1111 || od[3] !== 32'h9999) begin
            n_fail++; $display("FAIL extra_beat_drop got %h %h want 00001111 00009999", od[2], od[3]);
        end
    endtask

    task automatic test_illegal();
        int nv;
        for (int k = 0; k < 2; k++) begin
            run_read(k == 0 ? 32'h002 : 32'hFFC, k == 0 ? 8'd0 : 8'd1, '0, '0, 4);
            nv = 0;
            for (int c = 0; c < 4; c++) nv += int'(ov[c]);
            n_cmp++;
            if (oer[1] !== 1'b1 || oer[0] !== 1'b0 || oer[2] !== 1'b0) begin
                n_fail++; $display("FAIL illegal%0d_err got %b%b%b want 010", k, oer[0], oer[1], oer[2]);
            end
            n_cmp++;
            if (oe[2] !== 1'b1 || oe[1] !== 1'b0 || oe[3] !== 1'b0) begin
                n_fail++; $display("FAIL illegal%0d_end got %b%b%b want 010", k, oe[1], oe[2], oe[3]);
            end
            n_cmp++;
            if (nv !== 0) begin n_fail++; $display("FAIL illegal%0d_valid got %0d want 0", k, nv); end
        end
        bus_write(32'hFFC, 8'd0, 1, 128'hCAFE_0001, 16'hF);
        run_read(32'hFFC, 8'd0, '0, '0, 4);
        n_cmp++;
        if (ov[2] !== 1'b1 || od[2] !== 32'hCAFE_0001 || oer[1] !== 1'b0) begin
            n_fail++; $display("FAIL top_word got v=%b d=%h e=%b want v=1 d=cafe0001 e=0", ov[2], od[2], oer[1]);
        end
        run_read(32'h1000, 8'd0, '0, '0, 5);
        nv = 0;
        for (int c = 0; c < 5; c++) nv += int'(ov[c]) + int'(oe[c]) + int'(oer[c]);
        n_cmp++;
        if (nv !== 0) begin n_fail++; $display("FAIL miss_silent got %0d active want 0", nv); end
    endtask

    task automatic test_abort();
        run_read(32'h0, 8'd7, '0, 32'h8, 6);
        n_cmp++;
        if (ov[2] !== 1'b1 || od[2] !== 32'd1) begin
            n_fail++; $display("FAIL abort_first got v=%b d=%h want v=1 d=1", ov[2], od[2]);
        end
        n_cmp++;
        if ({ov[4], od[4], oe[4], oer[4], ov[5], oe[5], oe[3]} !== 38'd0) begin
            n_fail++; $display("FAIL abort_quiet got v4=%b d4=%h e4=%b r4=%b v5=%b e5=%b e3=%b want 0",
                               ov[4], od[4], oe[4], oer[4], ov[5], oe[5], oe[3]);
        end
        run_read(32'h400, 8'd0, '0, '0, 4);
        n_cmp++;
        if (ov[2] !== 1'b1 || od[2] !== 32'hDEAD_BEEF || oe[3] !== 1'b1) begin
            n_fail++; $display("FAIL abort_next got v=%b d=%h e=%b want v=1 d=deadbeef e=1", ov[2], od[2], oe[3]);
        end
    endtask

    task automatic test_reset_mid();
        b_begin = 1'b1; b_ad = 32'h40; b_burst = 8'd3; b_rnw = 1'b0;
        step();
        b_begin = 1'b0; b_burst = '0; b_be = 4'hF; b_dv = 1'b1; b_ad = 32'hA1;
        step();
        b_ad = 32'hA2;
        step();
        b_dv = 1'b0; b_ad = '0; b_be = '0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut.state !== IDLE || {o_ad, o_dv, o_end, o_err} !== 35'd0) begin
            n_fail++; $display("FAIL reset_wr_state got st=%0d out=%h want 0 0", dut.state, {o_ad, o_dv, o_end, o_err});
        end
        step();
        rst_n = 1'b1; b_rnw = 1'b1;
        step();
        run_read(32'h40, 8'd1, '0, '0, 5);
        n_cmp++;
        if (od[2] !== 32'hA1 || od[3] !== 32'hA2 || ov[2] !== 1'b1 || ov[3] !== 1'b1) begin
            n_fail++; $display("FAIL reset_retain got %h %h want 000000a1 000000a2", od[2], od[3]);
        end
        b_begin = 1'b1; b_ad = 32'h0; b_burst = 8'd3; b_rnw = 1'b1;
        step();
        b_begin = 1'b0; b_ad = '0; b_burst = '0;
        step();
        @(negedge clk);
        n_cmp++;
        if (o_dv !== 1'b1 || o_ad !== 32'd1) begin
            n_fail++; $display("FAIL reset_rd_pre got v=%b d=%h want v=1 d=1", o_dv, o_ad);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_ad, o_dv, o_end, o_err} !== 35'd0) begin
            n_fail++; $display("FAIL reset_rd_async got %h want 0", {o_ad, o_dv, o_end, o_err});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_stall();
        test_byte_enable();
        test_extra_beats();
        test_illegal();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sb_ram_slave.md
Name: sb_ram_slave

Overview:
- Single-port on-chip RAM acting as a responder (slave) on the shared system bus. It is the counterpart of bus initiators such as the JTAG debug unit.
- Decodes begin-transaction cycles that hit its address window, then serves single or burst reads and writes.
- Signals errors for illegal accesses.
- All bus outputs are driven to zero when not responding, so they can be OR'd onto the shared bus.

Parameters:
- BASE_ADDR, 32'h0000_0000: window base; must be aligned to the window size.
- ADDR_WIDTH, 10: log2 of window size in 32-bit words. Default window is 4 KiB.
- READ_LATENCY, 2: sys cycles from the begin_transaction cycle to the first read data beat; minimum 1.

Ports:
- sb_clock_i  in  1  system clock; all logic on rising edge.
- sb_reset_n_i  in  1  asynchronous, active-low reset.
- sb_begin_transaction_i  in  1  one-cycle start strobe from the granted master.
- sb_end_transaction_i  in  1  end strobe; master-driven on writes, arbiter-driven on timeouts.
- sb_address_data_i  in  32  address on the begin cycle; write data on data_valid cycles.
- sb_byte_enables_i  in  4  per-byte write enables; sampled on every write beat.
- sb_burst_size_i  in  8  beats minus one; sampled on the begin cycle.
- sb_read_n_write_i  in  1  1 = read, 0 = write; sampled on the begin cycle.
- sb_data_valid_i  in  1  master write beat valid.
- sb_busy_i  in  1  master stalls read data.
- sb_error_i  in  1  bus error (arbiter or other); aborts the transaction.
- sb_address_data_o  out  32  read data; 0 when not driving.
- sb_data_valid_o  out  1  read beat valid.
- sb_end_transaction_o  out  1  slave end strobe (reads and error terminations).
- sb_error_o  out  1  slave error strobe.
- sb_busy_o  out  1  tied 0; reserved.

Behaviour:
- Reset (async, sb_reset_n_i=0):
  - State goes to IDLE and counters clear.
  - Every output is 0 immediately.
  - RAM contents are preserved.
- Hit condition:
  - sb_begin_transaction_i=1 in IDLE and address[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2].
  - A begin outside IDLE is ignored.
  - A miss leaves the block in IDLE and silent.
- Illegal accesses:
  - Defined as a hit with address[1:0]!=0, or word_index + burst_size > 2^ADDR_WIDTH-1 (burst crosses the window top; no wrap).
  - Response is ERR for one cycle (sb_error_o=1), then ERR_END for one cycle (sb_end_transaction_o=1), then IDLE.
  - No RAM write occurs.
- States: IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, ERR, ERR_END.
- Read path:
  - Begin cycle latches word_index, beats = burst_size+1 (9-bit counter) and enters RD_WAIT.
  - RD_WAIT counts READ_LATENCY-1 cycles, prefetching RAM[word_index]; READ_LATENCY=1 goes directly to RD_DATA.
  - RD_DATA, one beat per cycle: sb_data_valid_o=1 and sb_address_data_o=RAM[index].
  - If sb_busy_i=1 in a cycle, that cycle outputs valid=0 and data=0, and the same word is re-presented next cycle; index does not advance.
  - After the last beat, RD_END drives sb_end_transaction_o=1 for exactly one cycle, then IDLE.
- Write path:
  - Begin cycle latches index and beats, then enters WR_DATA.
  - On each sb_data_valid_i=1, bytes with byte_enable=1 are written into RAM[index]; index increments and the beat count decrements.
  - Beats beyond burst_size+1 are dropped.
  - sb_end_transaction_i=1 returns to IDLE; a beat in the same cycle is still written.
  - The slave never drives end_transaction on writes.
- Abort:
  - sb_error_i=1 or sb_end_transaction_i=1 in any non-IDLE state other than ERR/ERR_END/WR_DATA-end returns to IDLE next cycle.
  - All outputs are 0 from that cycle on and no end strobe is issued.
- Output hygiene: sb_address_data_o is nonzero only while sb_data_valid_o=1.
- Read-after-write: a read issued after a write's end sees the written data.

Decomposition:
- Shared package sb_bus_pkg:
  - state enum sb_slave_state_t;
  - constants for bus widths (SB_DATA_W=32, SB_BURST_W=8, SB_BE_W=4).
- Sub-module sb_ram_array: 2^ADDR_WIDTH x 32 RAM with synchronous read, synchronous write and byte enables; one read/write port.

Test Plan:
- Single read:
  - Stimulus: preload RAM[0x400>>2]=32'hDEAD_BEEF; begin read at addr 0x400, burst 0.
  - Response: after 2 cycles one beat of DEAD_BEEF, then a one-cycle end strobe, then all outputs 0.
- Burst read with stall:
  - Stimulus: read at 0x0, burst 3 (words 0..3 = 1,2,3,4); busy_i=1 during beat 2.
  - Response: beats 1,2,(gap),3,4 with no word skipped or repeated, then end.
- Byte-enable write then read:
  - Stimulus: write at 0x10, burst 1, beats 32'hAABBCCDD BE=4'b1111 and 32'h11223344 BE=4'b0101; master end; then read at 0x10, burst 1.
  - Response: reads AABBCCDD and xx22xx44 (prior bytes kept).
- Illegal access:
  - Stimulus: read at 0x002 (unaligned), then read at 0xFFC with burst 1 (crosses top).
  - Response: each gives error 1 cycle, end 1 cycle, and no data_valid.
- Abort:
  - Stimulus: sb_error_i pulse during RD_DATA of a burst-7 read.
  - Response: outputs 0 next cycle, no end strobe, slave accepts a new begin immediately.
- Reset mid-burst:
  - Stimulus: drop sb_reset_n_i during a write burst.
  - Response: outputs 0 asynchronously, state IDLE, already-written words retained on a subsequent read.
